// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection phase scheduler.
package traffic_pkg;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;

  localparam logic [1:0] PH_NS_FWD  = 2'd0;
  localparam logic [1:0] PH_NS_LEFT = 2'd1;
  localparam logic [1:0] PH_EW_FWD  = 2'd2;
  localparam logic [1:0] PH_EW_LEFT = 2'd3;

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2
  } st_t;

  // Colour shown by a head belonging to phase 'head' given the active phase and state.
  function automatic logic [1:0] head_color(input st_t st, input logic [1:0] active,
                                            input logic [1:0] head);
    logic [1:0] c;
    c = LIGHT_RED;
    if (active == head) begin
      case (st)
        ST_GREEN:  c = LIGHT_GREEN;
        ST_YELLOW: c = LIGHT_YELLOW;
        default:   c = LIGHT_RED;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/phase_rr_arbiter.sv
// Round-robin pick of the next pending phase, searching from last+1 cyclically;
// the last-served phase is considered last.
module phase_rr_arbiter
  import traffic_pkg::*;
(
  input  logic [3:0] pending,
  input  logic [1:0] last,
  output logic [1:0] grant,
  output logic       valid
);

  logic [1:0] w_idx;

  // First set pending bit at offsets 1..4 from the last-served phase.
  always_comb begin
    grant = last;
    valid = 1'b0;
    w_idx = last;
    for (int unsigned i = 1; i <= 4; i++) begin
      w_idx = last + 2'(i);
      if (!valid && pending[w_idx]) begin
        grant = w_idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated four-phase scheduler with min/max green, fixed yellow,
// all-red clearance, round-robin service and emergency preemption.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_GREEN = 4,
  parameter int unsigned MAX_GREEN = 12,
  parameter int unsigned YELLOW    = 3,
  parameter int unsigned ALL_RED   = 2,
  parameter int unsigned CNT_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       preempt,
  input  logic [1:0] preempt_phase,
  output logic [1:0] N_forward,
  output logic [1:0] N_left,
  output logic [1:0] S_forward,
  output logic [1:0] S_left,
  output logic [1:0] E_forward,
  output logic [1:0] E_left,
  output logic [1:0] W_forward,
  output logic [1:0] W_left,
  output logic [1:0] phase,
  output logic       idle
);

  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALL_RED - 1);

  st_t              r_state, w_nxt_state;
  logic [CNT_W-1:0] r_timer, w_nxt_timer;
  logic [1:0]       r_phase, w_nxt_phase;
  logic [3:0]       r_pending, w_nxt_pending;
  logic [3:0]       w_phase_mask, w_req_set;
  logic             w_other;
  logic [1:0]       w_grant;
  logic             w_grant_valid;
  logic [1:0]       r_nf, r_nl, r_sf, r_sl, r_ef, r_el, r_wf, r_wl;
  logic             r_idle;

  phase_rr_arbiter u_arb (
    .pending (r_pending),
    .last    (r_phase),
    .grant   (w_grant),
    .valid   (w_grant_valid)
  );

  // Next-state, timer and pending-demand computation.
  always_comb begin
    w_phase_mask  = 4'b0001 << r_phase;
    w_other       = |(r_pending & ~w_phase_mask);
    // The green phase's own request is extension demand, not a new call.
    w_req_set     = (r_state == ST_GREEN) ? (req & ~w_phase_mask) : req;
    w_nxt_state   = r_state;
    w_nxt_phase   = r_phase;
    w_nxt_pending = r_pending | w_req_set;
    w_nxt_timer   = (r_timer == '1) ? r_timer : r_timer + 1'b1;
    case (r_state)
      ST_ALL_RED: begin
        if (r_timer >= AR_LAST) begin
          if (preempt) begin
            w_nxt_state = ST_GREEN;
            w_nxt_phase = preempt_phase;
          end else if (w_grant_valid) begin
            w_nxt_state = ST_GREEN;
            w_nxt_phase = w_grant;
          end
        end
      end
      ST_GREEN: begin
        if (preempt) begin
          if (preempt_phase != r_phase) w_nxt_state = ST_YELLOW;
        end else if (w_other && (((r_timer >= MIN_LAST) && !req[r_phase]) ||
                                 (r_timer >= MAX_LAST))) begin
          w_nxt_state = ST_YELLOW;
        end
      end
      ST_YELLOW: begin
        if (r_timer >= YEL_LAST) w_nxt_state = ST_ALL_RED;
      end
      default: w_nxt_state = ST_ALL_RED;
    endcase
    if (w_nxt_state != r_state) w_nxt_timer = '0;
    // Entering green serves the phase: its clear overrides any same-cycle request.
    if (w_nxt_state == ST_GREEN && r_state != ST_GREEN)
      w_nxt_pending = w_nxt_pending & ~(4'b0001 << w_nxt_phase);
  end

  // State register; head colours and idle are registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_ALL_RED;
      r_timer   <= '0;
      r_phase   <= PH_EW_LEFT;
      r_pending <= '0;
      r_nf      <= LIGHT_RED;
      r_nl      <= LIGHT_RED;
      r_sf      <= LIGHT_RED;
      r_sl      <= LIGHT_RED;
      r_ef      <= LIGHT_RED;
      r_el      <= LIGHT_RED;
      r_wf      <= LIGHT_RED;
      r_wl      <= LIGHT_RED;
      r_idle    <= 1'b1;
    end else begin
      r_state   <= w_nxt_state;
      r_timer   <= w_nxt_timer;
      r_phase   <= w_nxt_phase;
      r_pending <= w_nxt_pending;
      r_nf      <= head_color(w_nxt_state, w_nxt_phase, PH_NS_FWD);
      r_nl      <= head_color(w_nxt_state, w_nxt_phase, PH_NS_LEFT);
      r_sf      <= head_color(w_nxt_state, w_nxt_phase, PH_NS_FWD);
      r_sl      <= head_color(w_nxt_state, w_nxt_phase, PH_NS_LEFT);
      r_ef      <= head_color(w_nxt_state, w_nxt_phase, PH_EW_FWD);
      r_el      <= head_color(w_nxt_state, w_nxt_phase, PH_EW_LEFT);
      r_wf      <= head_color(w_nxt_state, w_nxt_phase, PH_EW_FWD);
      r_wl      <= head_color(w_nxt_state, w_nxt_phase, PH_EW_LEFT);
      r_idle    <= (w_nxt_state == ST_ALL_RED) && (w_nxt_pending == '0);
    end
  end

  assign N_forward = r_nf;
  assign N_left    = r_nl;
  assign S_forward = r_sf;
  assign S_left    = r_sl;
  assign E_forward = r_ef;
  assign E_left    = r_el;
  assign W_forward = r_wf;
  assign W_left    = r_wl;
  assign phase     = r_phase;
  assign idle      = r_idle;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler: table-driven gap-out sequence
// plus hand-written rest, max-out, round-robin, preemption and reset cases.
module tb_traffic_phase_scheduler;

  localparam logic [1:0] CR = 2'b00;
  localparam logic [1:0] CY = 2'b01;
  localparam logic [1:0] CG = 2'b10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       preempt = 1'b0;
  logic [1:0] preempt_phase = 2'd0;
  logic [1:0] N_forward, N_left, S_forward, S_left;
  logic [1:0] E_forward, E_left, W_forward, W_left;
  logic [1:0] phase;
  logic       idle;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [3:0] rq;
    logic       pr;
    logic [1:0] pp;
    logic [1:0] col;
    logic [1:0] ph;
    logic       idl;
  } vec_t;

  vec_t tbl [14];

  traffic_phase_scheduler #(
    .MIN_GREEN (4),
    .MAX_GREEN (12),
    .YELLOW    (3),
    .ALL_RED   (2),
    .CNT_W     (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .preempt       (preempt),
    .preempt_phase (preempt_phase),
    .N_forward     (N_forward),
    .N_left        (N_left),
    .S_forward     (S_forward),
    .S_left        (S_left),
    .E_forward     (E_forward),
    .E_left        (E_left),
    .W_forward     (W_forward),
    .W_left        (W_left),
    .phase         (phase),
    .idle          (idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [1:0] col, input logic [1:0] ph,
                       input logic idl);
    logic [15:0] exp_h, act_h;
    act_h = {N_forward, N_left, S_forward, S_left, E_forward, E_left, W_forward, W_left};
    case (ph)
      2'd0:    exp_h = {col, 2'b00, col, 2'b00, 8'h00};
      2'd1:    exp_h = {2'b00, col, 2'b00, col, 8'h00};
      2'd2:    exp_h = {8'h00, col, 2'b00, col, 2'b00};
      default: exp_h = {8'h00, 2'b00, col, 2'b00, col};
    endcase
    checks++;
    if (act_h !== exp_h) begin
      errors++;
      $display("FAIL %s heads got %h want %h", nm, act_h, exp_h);
    end
    checks++;
    if (phase !== ph) begin
      errors++;
      $display("FAIL %s phase got %0d want %0d", nm, phase, ph);
    end
    checks++;
    if (idle !== idl) begin
      errors++;
      $display("FAIL %s idle got %0b want %0b", nm, idle, idl);
    end
  endtask

  task automatic run(input string nm, input int unsigned n, input logic [3:0] rq,
                     input logic pr, input logic [1:0] pp, input logic [1:0] col,
                     input logic [1:0] ph, input logic idl);
    for (int unsigned i = 0; i < n; i++) begin
      req = rq;
      preempt = pr;
      preempt_phase = pp;
      @(posedge clk);
      #1;
      check($sformatf("%s_%0d", nm, i), col, ph, idl);
    end
  endtask

  task automatic do_reset();
    req = 4'b0000;
    preempt = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst", CR, 2'd3, 1'b1);
  endtask

  initial begin
    // P0 green, req[0] dropped, P2 pulsed at green cycle 1: gap-out after MIN_GREEN.
    tbl[0]  = '{4'b0001, 1'b0, 2'd0, CR, 2'd3, 1'b0};
    tbl[1]  = '{4'b0001, 1'b0, 2'd0, CG, 2'd0, 1'b0};
    tbl[2]  = '{4'b0000, 1'b0, 2'd0, CG, 2'd0, 1'b0};
    tbl[3]  = '{4'b0100, 1'b0, 2'd0, CG, 2'd0, 1'b0};
    tbl[4]  = '{4'b0000, 1'b0, 2'd0, CG, 2'd0, 1'b0};
    tbl[5]  = '{4'b0000, 1'b0, 2'd0, CY, 2'd0, 1'b0};
    tbl[6]  = '{4'b0000, 1'b0, 2'd0, CY, 2'd0, 1'b0};
    tbl[7]  = '{4'b0000, 1'b0, 2'd0, CY, 2'd0, 1'b0};
    tbl[8]  = '{4'b0000, 1'b0, 2'd0, CR, 2'd0, 1'b0};
    tbl[9]  = '{4'b0000, 1'b0, 2'd0, CR, 2'd0, 1'b0};
    tbl[10] = '{4'b0000, 1'b0, 2'd0, CG, 2'd2, 1'b0};
    tbl[11] = '{4'b0000, 1'b0, 2'd0, CG, 2'd2, 1'b0};
    tbl[12] = '{4'b0000, 1'b0, 2'd0, CG, 2'd2, 1'b0};
    tbl[13] = '{4'b0000, 1'b0, 2'd0, CG, 2'd2, 1'b0};

    #2 reset = 1'b1;
    #2 check("por", CR, 2'd3, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // Rest in green with own request held; no pending leaks for P0.
    run("A_ar", 1, 4'b0001, 1'b0, 2'd0, CR, 2'd3, 1'b0);
    run("A_g", 21, 4'b0001, 1'b0, 2'd0, CG, 2'd0, 1'b0);
    run("A_g0", 3, 4'b0000, 1'b0, 2'd0, CG, 2'd0, 1'b0);
    run("A_call", 1, 4'b0100, 1'b0, 2'd0, CG, 2'd0, 1'b0);
    run("A_y", 3, 4'b0000, 1'b0, 2'd0, CY, 2'd0, 1'b0);
    run("A_r", 2, 4'b0000, 1'b0, 2'd0, CR, 2'd0, 1'b0);
    run("A_g2", 10, 4'b0000, 1'b0, 2'd0, CG, 2'd2, 1'b0);

    // Table-driven gap-out sequence.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      req = tbl[i].rq;
      preempt = tbl[i].pr;
      preempt_phase = tbl[i].pp;
      @(posedge clk);
      #1;
      check($sformatf("B_%0d", i), tbl[i].col, tbl[i].ph, tbl[i].idl);
    end

    // Max-out: P0 held, P2 waiting.
    do_reset();
    run("C_ar", 1, 4'b0101, 1'b0, 2'd0, CR, 2'd3, 1'b0);
    run("C_g", 12, 4'b0101, 1'b0, 2'd0, CG, 2'd0, 1'b0);
    run("C_y", 3, 4'b0101, 1'b0, 2'd0, CY, 2'd0, 1'b0);
    run("C_r", 2, 4'b0101, 1'b0, 2'd0, CR, 2'd0, 1'b0);
    run("C_g2", 1, 4'b0101, 1'b0, 2'd0, CG, 2'd2, 1'b0);

    // Round-robin P1, P2, P3 after P0.
    do_reset();
    run("D_ar", 1, 4'b0001, 1'b0, 2'd0, CR, 2'd3, 1'b0);
    run("D_g0", 1, 4'b0001, 1'b0, 2'd0, CG, 2'd0, 1'b0);
    run("D_call", 1, 4'b1110, 1'b0, 2'd0, CG, 2'd0, 1'b0);
    run("D_g0b", 2, 4'b0000, 1'b0, 2'd0, CG, 2'd0, 1'b0);
    run("D_y0", 3, 4'b0000, 1'b0, 2'd0, CY, 2'd0, 1'b0);
    run("D_r0", 2, 4'b0000, 1'b0, 2'd0, CR, 2'd0, 1'b0);
    for (int p = 1; p <= 2; p++) begin
      run($sformatf("D_g%0d", p), 4, 4'b0000, 1'b0, 2'd0, CG, 2'(p), 1'b0);
      run($sformatf("D_y%0d", p), 3, 4'b0000, 1'b0, 2'd0, CY, 2'(p), 1'b0);
      run($sformatf("D_r%0d", p), 2, 4'b0000, 1'b0, 2'd0, CR, 2'(p), 1'b0);
    end
    run("D_g3", 6, 4'b0000, 1'b0, 2'd0, CG, 2'd3, 1'b0);

    // Preemption to P3 from P0 green cycle 1, P0 served after release.
    do_reset();
    run("E_ar", 1, 4'b0001, 1'b0, 2'd0, CR, 2'd3, 1'b0);
    run("E_g0", 2, 4'b0001, 1'b0, 2'd0, CG, 2'd0, 1'b0);
    run("E_py", 3, 4'b0001, 1'b1, 2'd3, CY, 2'd0, 1'b0);
    run("E_pr", 2, 4'b0001, 1'b1, 2'd3, CR, 2'd0, 1'b0);
    run("E_pg", 16, 4'b0001, 1'b1, 2'd3, CG, 2'd3, 1'b0);
    run("E_y3", 3, 4'b0000, 1'b0, 2'd0, CY, 2'd3, 1'b0);
    run("E_r3", 2, 4'b0000, 1'b0, 2'd0, CR, 2'd3, 1'b0);
    run("E_g0b", 3, 4'b0000, 1'b0, 2'd0, CG, 2'd0, 1'b0);

    // Reset mid-yellow; requests during reset are dropped.
    do_reset();
    run("F_ar", 1, 4'b0001, 1'b0, 2'd0, CR, 2'd3, 1'b0);
    run("F_g", 2, 4'b0001, 1'b0, 2'd0, CG, 2'd0, 1'b0);
    run("F_call", 1, 4'b0100, 1'b0, 2'd0, CG, 2'd0, 1'b0);
    run("F_g2", 1, 4'b0000, 1'b0, 2'd0, CG, 2'd0, 1'b0);
    run("F_y", 2, 4'b0000, 1'b0, 2'd0, CY, 2'd0, 1'b0);
    #2;
    reset = 1'b1;
    req = 4'b1111;
    #1;
    check("F_async", CR, 2'd3, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("F_hold_%0d", i), CR, 2'd3, 1'b1);
    end
    reset = 1'b0;
    run("F_idle", 3, 4'b0000, 1'b0, 2'd0, CR, 2'd3, 1'b1);
    run("F_ar2", 1, 4'b0001, 1'b0, 2'd0, CR, 2'd3, 1'b0);
    run("F_gn", 1, 4'b0001, 1'b0, 2'd0, CG, 2'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Demand-actuated phase scheduler for the four-way intersection. It drives the eight 2-bit signal heads (N/S/E/W forward and left) from per-phase vehicle requests and an emergency preemption input. It enforces min/max green, fixed yellow and all-red clearance, and serves competing phases round-robin. It replaces fixed-cycle sequencing as the source of the light outputs consumed by the intersection top level.

## Interface
- MIN_GREEN, 4: minimum green cycles per service
- MAX_GREEN, 12: green cycle limit while other demand waits; must be ≥ MIN_GREEN
- YELLOW, 3: yellow cycles, exact
- ALL_RED, 2: all-red clearance cycles, minimum
- CNT_W, 4: timer width; must hold MAX_GREEN
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; all state cleared immediately
- req  in  4  phase demand; bit0 NS-forward, bit1 NS-left, bit2 EW-forward, bit3 EW-left
- preempt  in  1  emergency preemption, level
- preempt_phase  in  2  phase to force while preempt=1
- N_forward, N_left, S_forward, S_left, E_forward, E_left, W_forward, W_left  out  2 each  00 red, 01 yellow, 10 green; 11 never driven
- phase  out  2  current or last-served phase
- idle  out  1  1 while in ALL_RED with no pending demand

## Operation
- Phases: P0 = N+S forward, P1 = N+S left, P2 = E+W forward, P3 = E+W left. Only the heads of the active phase are ever non-red.
- States: ALL_RED, GREEN, YELLOW.
- Reset values: state ALL_RED, timer 0, phase 3 (so the first round-robin search starts at P0), pending 0, all heads 00, idle 1.
- pending[3:0] is sticky. A req bit sets it every cycle, except the req bit of the phase currently in GREEN, which counts as extension demand. The pending bit of P clears on the cycle GREEN of P is entered; the clear wins over a same-cycle set.
- ALL_RED: timer counts. Once timer ≥ ALL_RED-1 and demand exists, next state is GREEN.
  - If preempt=1, the target phase is preempt_phase, regardless of pending.
  - Otherwise the target is the first pending phase searching phase+1, phase+2, … cyclically. The current phase is eligible last.
  - With no demand, remain in ALL_RED (idle=1).
- GREEN: timer counts from 0 on entry. Exit to YELLOW when any of these holds:
  - preempt=1 and preempt_phase ≠ phase (immediate, ignores MIN_GREEN);
  - timer ≥ MIN_GREEN-1, other pending demand exists, req[phase]=0 (gap-out);
  - timer ≥ MAX_GREEN-1 and other pending demand exists (max-out).
- With no other demand, rest in GREEN indefinitely. While preempt=1 and preempt_phase = phase, hold GREEN.
- YELLOW: exactly YELLOW cycles, never shortened by preemption, then ALL_RED.
- Preempt release: normal rules resume next cycle; a phase still pending keeps its pending bit.

## Timing
- Outputs decode from registered state/phase only; there is no combinational path from input to output.
- An input sampled at edge k affects outputs after edge k.
- Every transition resets the timer to 0. The timer saturates at its maximum value and never wraps.
- Minimum service sequence: GREEN ≥ MIN_GREEN cycles (except under preempt), YELLOW = YELLOW, ALL_RED ≥ ALL_RED.
- Reset asserted mid-GREEN/YELLOW: heads go to 00 asynchronously and pending is lost. After release, ALL_RED clearance is counted in full before any green.

## Structure
- Package traffic_pkg holds:
  - light encodings LIGHT_RED/LIGHT_YELLOW/LIGHT_GREEN;
  - phase constants PH_NS_FWD, PH_NS_LEFT, PH_EW_FWD, PH_EW_LEFT;
  - state enum st_t (ST_ALL_RED, ST_GREEN, ST_YELLOW).
- Sub-module phase_rr_arbiter is combinational: inputs pending[3:0] and last[1:0]; outputs grant[1:0] and valid.

## Test plan
- Reset, release with req=0001 held: all heads 00 for 2 cycles, then N/S_forward=10 with all others 00. It rests green indefinitely and pending stays 0.
- P0 green with req[0] dropped, req=0100 pulsed at green cycle 1: yellow starts after green cycle 3 (MIN_GREEN). Yellow lasts 3 cycles, then 2 all-red cycles, then E/W_forward=10.
- P0 green with req[0] held high and req[2] pending: max-out, so yellow starts after green cycle 11.
- Pending 1110 with phase 0 last served: service order is P1, P2, P3. phase output steps 1→2→3, each separated by 3 yellow + 2 all-red cycles.
- In P0 green cycle 1, preempt=1 with preempt_phase=3: immediate yellow (3 cycles), all-red (2), then E/W_left=10. This holds while preempt=1 even though pending 0001 exists; P0 is served after release.
- Reset asserted mid-yellow: all heads 00 at once and idle=1. Requests seen during reset are not retained.
